// File: rtl/pio_pkg.sv
// Shared definitions for the pio command loader: action codes, loader states, frame length.
// Frame length depends on PIO_CMD_CHECKSUM_EN (7 bytes with trailing XOR checksum, else 6).
package pio_pkg;

  localparam logic [3:0] ACT_NOP       = 4'd0;
  localparam logic [3:0] ACT_INSTR     = 4'd1;
  localparam logic [3:0] ACT_PEND      = 4'd2;
  localparam logic [3:0] ACT_PULL      = 4'd3;
  localparam logic [3:0] ACT_PUSH      = 4'd4;
  localparam logic [3:0] ACT_PINS      = 4'd5;
  localparam logic [3:0] ACT_EN        = 4'd6;
  localparam logic [3:0] ACT_DIV       = 4'd7;
  localparam logic [3:0] ACT_SIDESET   = 4'd8;
  localparam logic [3:0] ACT_IMM       = 4'd9;
  localparam logic [3:0] ACT_APUSH     = 4'd10;
  localparam logic [3:0] ACT_APULL     = 4'd11;
  localparam logic [3:0] ACT_INIT_PINS = 4'd12;
  localparam logic [3:0] ACT_INIT_DIRS = 4'd13;
  localparam logic [3:0] ACT_ISR_TH    = 4'd14;
  localparam logic [3:0] ACT_OSR_TH    = 4'd15;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_COLLECT,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } ld_state_e;

`ifdef PIO_CMD_CHECKSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

endpackage

// File: rtl/pio_cmd_serializer.sv
// Sends a 32-bit word as four bytes, LSB first, over a valid/ready byte stream.
module pio_cmd_serializer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [31:0] shift_q;
  logic [1:0]  cnt_q;
  logic        valid_q;
  logic        hs;

  assign hs         = valid_q && tx_ready_i;
  assign done_o     = hs && (cnt_q == 2'd3);
  assign tx_data_o  = shift_q[7:0];
  assign tx_valid_o = valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shift_q <= data_i;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (hs) begin
      // Shifting in zeros leaves tx_data at 0 once the last byte has gone.
      shift_q <= {8'h00, shift_q[31:8]};
      cnt_q   <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pio_cmd_loader.sv
// Assembles UART command frames into pio control-bus strobes and returns pulled FIFO words.
// Optional PIO_CMD_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
module pio_cmd_loader
  import pio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned DOUT_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [3:0]  action,
  output logic [1:0]  mindex,
  output logic [4:0]  index,
  output logic [31:0] din,
  input  logic [31:0] dout,
  output logic        busy,
  output logic        frame_err,
  output logic [15:0] cmd_count
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  ld_state_e   state_q;
  logic [2:0]  cnt_q;
  logic [3:0]  act_sh_q;
  logic [1:0]  mindex_sh_q;
  logic [4:0]  index_sh_q;
  logic [31:0] din_sh_q;
  logic [31:0] to_q;
  logic [31:0] wait_q;
  logic        rx_ready_q, busy_q, frame_err_q;
  logic [3:0]  action_q;
  logic [1:0]  mindex_q;
  logic [4:0]  index_q;
  logic [31:0] din_q;
  logic [15:0] cmd_count_q;

  logic        accept, last_byte, to_hit, frame_ok, load, ser_done;
  logic [31:0] din_d;

  assign accept    = rx_valid && rx_ready_q;
  assign last_byte = (cnt_q == LAST_IDX);
  assign to_hit    = (TIMEOUT_CYCLES != 0) && (to_q == TIMEOUT_CYCLES - 1);
  assign load      = ((state_q == ST_WAIT) && (wait_q == DOUT_LATENCY - 1)) ||
                     ((state_q == ST_ISSUE) && (action_q == ACT_PULL) && (DOUT_LATENCY == 0));

  // Shadow din with the byte currently on rx_data merged in, so ISSUE can see B5 directly.
  always_comb begin
    din_d = din_sh_q;
    case (cnt_q)
      3'd2:    din_d[7:0]   = rx_data;
      3'd3:    din_d[15:8]  = rx_data;
      3'd4:    din_d[23:16] = rx_data;
      3'd5:    din_d[31:24] = rx_data;
      default: din_d = din_sh_q;
    endcase
  end

`ifdef PIO_CMD_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      csum_q <= '0;
    else if (accept) csum_q <= (state_q == ST_HDR) ? rx_data : (csum_q ^ rx_data);
  end

  assign frame_ok = (csum_q == rx_data);
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HDR;
      cnt_q       <= '0;
      act_sh_q    <= '0;
      mindex_sh_q <= '0;
      index_sh_q  <= '0;
      din_sh_q    <= '0;
      to_q        <= '0;
      wait_q      <= '0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      action_q    <= '0;
      mindex_q    <= '0;
      index_q     <= '0;
      din_q       <= '0;
      cmd_count_q <= '0;
    end else begin
      action_q    <= ACT_NOP;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_HDR: begin
          rx_ready_q <= 1'b1;
          if (accept) begin
            act_sh_q    <= rx_data[7:4];
            mindex_sh_q <= rx_data[3:2];
            cnt_q       <= 3'd1;
            to_q        <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            cnt_q    <= cnt_q + 3'd1;
            to_q     <= '0;
            din_sh_q <= din_d;
            if (cnt_q == 3'd1) index_sh_q <= rx_data[4:0];
            if (last_byte && frame_ok) begin
              rx_ready_q  <= 1'b0;
              action_q    <= act_sh_q;
              mindex_q    <= mindex_sh_q;
              index_q     <= index_sh_q;
              din_q       <= din_d;
              cmd_count_q <= cmd_count_q + 16'd1;
              state_q     <= ST_ISSUE;
            end else if (last_byte) begin
              frame_err_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_HDR;
            end
          end else if (to_hit) begin
            frame_err_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_HDR;
          end else begin
            to_q <= to_q + 32'd1;
          end
        end
        ST_ISSUE: begin
          wait_q <= '0;
          if (action_q == ACT_PULL) begin
            state_q <= (DOUT_LATENCY == 0) ? ST_RESP : ST_WAIT;
          end else begin
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_HDR;
          end
        end
        ST_WAIT: begin
          if (load) state_q <= ST_RESP;
          else      wait_q  <= wait_q + 32'd1;
        end
        ST_RESP: begin
          if (ser_done) begin
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_HDR;
          end
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  pio_cmd_serializer u_ser (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (load),
    .data_i     (dout),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .done_o     (ser_done)
  );

  assign rx_ready  = rx_ready_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign action    = action_q;
  assign mindex    = mindex_q;
  assign index     = index_q;
  assign din       = din_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_pio_cmd_loader.sv
// Directed bench for pio_cmd_loader; checksum vectors are added when PIO_CMD_CHECKSUM_EN is defined.
module tb_pio_cmd_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  action;
  logic [1:0]  mindex;
  logic [4:0]  index;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy;
  logic        frame_err;
  logic [15:0] cmd_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pio_cmd_loader #(.TIMEOUT_CYCLES(16), .DOUT_LATENCY(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .action    (action),
    .mindex    (mindex),
    .index     (index),
    .din       (din),
    .dout      (dout),
    .busy      (busy),
    .frame_err (frame_err),
    .cmd_count (cmd_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    step();
    rx_valid = 1'b0;
  endtask

  // fr holds B0 in its top byte and B5 in its bottom byte.
  task automatic send_frame(input logic [47:0] fr);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b  = fr[47-8*i -: 8];
      cs = cs ^ b;
      send_byte(b);
    end
`ifdef PIO_CMD_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

`ifdef PIO_CMD_CHECKSUM_EN
  task automatic send_bad_frame(input logic [47:0] fr);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b  = fr[47-8*i -: 8];
      cs = cs ^ b;
      send_byte(b);
    end
    send_byte(cs ^ 8'h01);
  endtask
`endif

  initial begin
    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    dout     = 32'h0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_action",    32'(action),    32'd0);
    chk("rst_mindex",    32'(mindex),    32'd0);
    chk("rst_index",     32'(index),     32'd0);
    chk("rst_din",       din,            32'd0);
    chk("rst_tx_valid",  32'(tx_valid),  32'd0);
    chk("rst_tx_data",   32'(tx_data),   32'd0);
    chk("rst_rx_ready",  32'(rx_ready),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_cmd_count", 32'(cmd_count), 32'd0);
    reset = 1'b1;
    chk("rel_rx_ready_lo", 32'(rx_ready), 32'd0);
    step();
    chk("rel_rx_ready_hi", 32'(rx_ready), 32'd1);

    // Frame 1: action 1, index 3, din 0x1234
    send_frame(48'h10_03_34_12_00_00);
    chk("f1_action",    32'(action),    32'd1);
    chk("f1_mindex",    32'(mindex),    32'd0);
    chk("f1_index",     32'(index),     32'd3);
    chk("f1_din",       din,            32'h0000_1234);
    chk("f1_cmd_count", 32'(cmd_count), 32'd1);
    chk("f1_rx_ready",  32'(rx_ready),  32'd0);
    chk("f1_busy",      32'(busy),      32'd1);
    step();
    chk("f1_action_off", 32'(action),   32'd0);
    chk("f1_din_hold",   din,           32'h0000_1234);
    chk("f1_tx_valid",   32'(tx_valid), 32'd0);
    chk("f1_busy_off",   32'(busy),     32'd0);
    chk("f1_rx_ready",   32'(rx_ready), 32'd1);

    // Frame 2: FIFO pull, dout returned LSB first with a stalled second byte
    dout = 32'hDEAD_BEEF;
    send_frame(48'h30_00_00_00_00_00);
    chk("f2_action",    32'(action),    32'd3);
    chk("f2_mindex",    32'(mindex),    32'd0);
    chk("f2_cmd_count", 32'(cmd_count), 32'd2);
    step();
    chk("f2_action_off", 32'(action),   32'd0);
    chk("f2_wait_txv",   32'(tx_valid), 32'd0);
    step();
    chk("f2_txv0", 32'(tx_valid), 32'd1);
    chk("f2_txd0", 32'(tx_data),  32'hEF);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("f2_stall_txv", 32'(tx_valid), 32'd1);
      chk("f2_stall_txd", 32'(tx_data),  32'hBE);
      step();
    end
    tx_ready = 1'b1;
    step();
    chk("f2_txd2", 32'(tx_data), 32'hAD);
    step();
    chk("f2_txd3", 32'(tx_data), 32'hDE);
    chk("f2_busy", 32'(busy),    32'd1);
    step();
    tx_ready = 1'b0;
    chk("f2_txv_done",  32'(tx_valid), 32'd0);
    chk("f2_busy_done", 32'(busy),     32'd0);
    chk("f2_rx_ready",  32'(rx_ready), 32'd1);

    // Frame 3: action 6 on machine 1
    send_frame(48'h64_00_0F_00_00_00);
    chk("f3_action",    32'(action),    32'd6);
    chk("f3_mindex",    32'(mindex),    32'd1);
    chk("f3_index",     32'(index),     32'd0);
    chk("f3_din",       din,            32'h0000_000F);
    chk("f3_cmd_count", 32'(cmd_count), 32'd3);
    step();

    // Partial frame timeout after 16 idle cycles
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (15) step();
    chk("to_err_early", 32'(frame_err), 32'd0);
    chk("to_busy_early", 32'(busy),     32'd1);
    step();
    chk("to_err_pulse", 32'(frame_err), 32'd1);
    chk("to_busy",      32'(busy),      32'd0);
    chk("to_cmd_count", 32'(cmd_count), 32'd3);
    step();
    chk("to_err_end",   32'(frame_err), 32'd0);
    send_frame(48'h20_04_78_56_34_12);
    chk("to_next_action", 32'(action),    32'd2);
    chk("to_next_index",  32'(index),     32'd4);
    chk("to_next_din",    din,            32'h1234_5678);
    chk("to_next_count",  32'(cmd_count), 32'd4);
    step();

    // Reset asserted mid-response
    dout = 32'hCAFE_F00D;
    send_frame(48'h30_00_00_00_00_00);
    step();
    step();
    chk("rr_txd0", 32'(tx_data), 32'h0D);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("rr_txd1", 32'(tx_data), 32'hF0);
    reset = 1'b0;
    #1;
    chk("rr_tx_valid",  32'(tx_valid),  32'd0);
    chk("rr_tx_data",   32'(tx_data),   32'd0);
    chk("rr_busy",      32'(busy),      32'd0);
    chk("rr_rx_ready",  32'(rx_ready),  32'd0);
    chk("rr_cmd_count", 32'(cmd_count), 32'd0);
    chk("rr_action",    32'(action),    32'd0);
    step();
    reset = 1'b1;
    step();
    chk("rr_rel_rx_ready", 32'(rx_ready), 32'd1);
    chk("rr_rel_busy",     32'(busy),     32'd0);
    chk("rr_rel_txv",      32'(tx_valid), 32'd0);

`ifdef PIO_CMD_CHECKSUM_EN
    // Good and corrupted checksum
    send_frame(48'h10_05_01_00_00_00);
    chk("cs_ok_action", 32'(action),    32'd1);
    chk("cs_ok_count",  32'(cmd_count), 32'd1);
    step();
    send_bad_frame(48'h10_05_01_00_00_00);
    chk("cs_bad_err",    32'(frame_err), 32'd1);
    chk("cs_bad_action", 32'(action),    32'd0);
    chk("cs_bad_count",  32'(cmd_count), 32'd1);
    chk("cs_bad_busy",   32'(busy),      32'd0);
    step();
    chk("cs_bad_err_end", 32'(frame_err), 32'd0);
    chk("cs_bad_noact",   32'(action),    32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
